// File: rtl/block_tdpram_be.sv
// True dual-port, single-clock block RAM with per-byte write enables, selectable
// same-port read mode, optional output pipeline stage, read-valid strobes and a collision flag.
module block_tdpram_be #(
    parameter int p_data_width    = 32,
    parameter int p_byte_width    = 8,
    parameter int p_address_width = 10,
    parameter int p_depth         = 2 ** p_address_width,
    parameter int p_read_mode     = 0,
    parameter int p_out_reg       = 0
) (
    input  logic                                   i_w_clk,
    input  logic                                   i_w_rst_n,
    input  logic                                   i_w_cs_a,
    input  logic [p_data_width/p_byte_width-1:0]   i_w_we_a,
    input  logic [p_address_width-1:0]             i_w_address_a,
    input  logic [p_data_width-1:0]                i_w_in_a,
    output logic [p_data_width-1:0]                o_r_out_a,
    output logic                                   o_r_valid_a,
    input  logic                                   i_w_cs_b,
    input  logic [p_data_width/p_byte_width-1:0]   i_w_we_b,
    input  logic [p_address_width-1:0]             i_w_address_b,
    input  logic [p_data_width-1:0]                i_w_in_b,
    output logic [p_data_width-1:0]                o_r_out_b,
    output logic                                   o_r_valid_b,
    output logic                                   o_r_collision
);

    localparam int l_p_lanes = p_data_width / p_byte_width;
    localparam logic [p_address_width:0] l_depth = (p_address_width + 1)'(p_depth);

    (* ram_style = "block" *) logic [p_data_width-1:0] mem_q [0:p_depth-1];

    logic                    in_rng_a_s, in_rng_b_s;
    logic                    wr_a_s, wr_b_s;
    logic [p_data_width-1:0] old_a_s, old_b_s;
    logic [p_data_width-1:0] out_a_d, out_b_d, out_a_q, out_b_q;
    logic                    vld_a_q, vld_b_q;
    logic                    coll_d, coll_q;

    function automatic logic [p_data_width-1:0] f_merge(
        input logic [p_data_width-1:0] old_w,
        input logic [p_data_width-1:0] new_w,
        input logic [l_p_lanes-1:0]    we
    );
        logic [p_data_width-1:0] res;
        res = old_w;
        for (int l = 0; l < l_p_lanes; l++) begin
            if (we[l]) begin
                res[l*p_byte_width +: p_byte_width] = new_w[l*p_byte_width +: p_byte_width];
            end else begin
                res[l*p_byte_width +: p_byte_width] = old_w[l*p_byte_width +: p_byte_width];
            end
        end
        return res;
    endfunction

    // Same-port read data: old word, merged word, or hold, depending on the read mode.
    function automatic logic [p_data_width-1:0] f_next_out(
        input logic                    cs,
        input logic                    in_rng,
        input logic [l_p_lanes-1:0]    we,
        input logic [p_data_width-1:0] old_w,
        input logic [p_data_width-1:0] din,
        input logic [p_data_width-1:0] prev
    );
        logic [p_data_width-1:0] res;
        res = prev;
        if (!cs) begin
            res = prev;
        end else if (!in_rng) begin
            res = '0;
        end else if (we == '0) begin
            res = old_w;
        end else begin
            case (p_read_mode)
                32'sd1:  res = f_merge(old_w, din, we);
                32'sd2:  res = prev;
                default: res = old_w;
            endcase
        end
        return res;
    endfunction

    // Address decode, array read and next-state for both ports.
    always_comb begin
        in_rng_a_s = ({1'b0, i_w_address_a} < l_depth);
        in_rng_b_s = ({1'b0, i_w_address_b} < l_depth);
        if (in_rng_a_s) begin
            old_a_s = mem_q[i_w_address_a];
        end else begin
            old_a_s = '0;
        end
        if (in_rng_b_s) begin
            old_b_s = mem_q[i_w_address_b];
        end else begin
            old_b_s = '0;
        end
        wr_a_s  = i_w_rst_n & i_w_cs_a & (|i_w_we_a) & in_rng_a_s;
        wr_b_s  = i_w_rst_n & i_w_cs_b & (|i_w_we_b) & in_rng_b_s;
        coll_d  = wr_a_s & wr_b_s & (i_w_address_a == i_w_address_b);
        out_a_d = f_next_out(i_w_cs_a, in_rng_a_s, i_w_we_a, old_a_s, i_w_in_a, out_a_q);
        out_b_d = f_next_out(i_w_cs_b, in_rng_b_s, i_w_we_b, old_b_s, i_w_in_b, out_b_q);
    end

    // Array write: port B first so port A overrides every lane it enables on a collision.
    always_ff @(posedge i_w_clk) begin
        for (int l = 0; l < l_p_lanes; l++) begin
            if (wr_b_s && i_w_we_b[l]) begin
                mem_q[i_w_address_b][l*p_byte_width +: p_byte_width] <= i_w_in_b[l*p_byte_width +: p_byte_width];
            end
            if (wr_a_s && i_w_we_a[l]) begin
                mem_q[i_w_address_a][l*p_byte_width +: p_byte_width] <= i_w_in_a[l*p_byte_width +: p_byte_width];
            end
        end
    end

    // First output stage: read data, valid strobes and collision flag.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            out_a_q <= '0;
            out_b_q <= '0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            vld_a_q <= i_w_cs_a;
            vld_b_q <= i_w_cs_b;
            coll_q  <= coll_d;
        end
    end

    generate
        if (p_out_reg != 0) begin : g_out_reg
            logic [p_data_width-1:0] out2_a_q, out2_b_q;
            logic                    vld2_a_q, vld2_b_q;

            // Second output stage follows the first every cycle; reset drops in-flight reads.
            always_ff @(posedge i_w_clk) begin
                if (!i_w_rst_n) begin
                    out2_a_q <= '0;
                    out2_b_q <= '0;
                    vld2_a_q <= 1'b0;
                    vld2_b_q <= 1'b0;
                end else begin
                    out2_a_q <= out_a_q;
                    out2_b_q <= out_b_q;
                    vld2_a_q <= vld_a_q;
                    vld2_b_q <= vld_b_q;
                end
            end

            assign o_r_out_a   = out2_a_q;
            assign o_r_out_b   = out2_b_q;
            assign o_r_valid_a = vld2_a_q;
            assign o_r_valid_b = vld2_b_q;
        end else begin : g_no_out_reg
            assign o_r_out_a   = out_a_q;
            assign o_r_out_b   = out_b_q;
            assign o_r_valid_a = vld_a_q;
            assign o_r_valid_b = vld_b_q;
        end
    endgenerate

    assign o_r_collision = coll_q;

endmodule
